// File: rtl/ex_issue_ctrl_pkg.sv
// Shared constants for the ID/EX issue controller.
// Op-word layout, bubble encoding, forwarding codes and FSM states.
package ex_issue_ctrl_pkg;

  localparam int OP_W_DEF   = 12;
  localparam int REG_AW_DEF = 5;

  localparam int BR_OP_LSB  = 9;
  localparam int ALU_OP_LSB = 5;
  localparam int SRC_A      = 4;
  localparam int SRC_B      = 3;
  localparam int ALU_EN     = 2;
  localparam int BR_EN      = 1;
  localparam int WORK_EN    = 0;

  localparam logic [11:0] EX_NOP = 12'h1E0;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_KILL = 1'b1
  } state_e;

endpackage

// File: rtl/ex_issue_ctrl_if.sv
// ID-side bundle: decoded instruction toward EX, stall back to ID.
interface ex_issue_ctrl_if #(
  parameter int OP_W   = 12,
  parameter int REG_AW = 5
);
  logic              idValid;
  logic [OP_W-1:0]   idExOp;
  logic [REG_AW-1:0] idRs1Addr;
  logic [REG_AW-1:0] idRs2Addr;
  logic [REG_AW-1:0] idRdAddr;
  logic              idUseRs1;
  logic              idUseRs2;
  logic              idIsLoad;
  logic              idRegWrite;
  logic              idReady;

  modport master (
    output idValid, idExOp,
    output idRs1Addr, idRs2Addr, idRdAddr,
    output idUseRs1, idUseRs2,
    output idIsLoad, idRegWrite,
    input  idReady
  );

  modport slave (
    input  idValid, idExOp,
    input  idRs1Addr, idRs2Addr, idRdAddr,
    input  idUseRs1, idUseRs2,
    input  idIsLoad, idRegWrite,
    output idReady
  );
endinterface

// File: rtl/ex_issue_ctrl_fwd.sv
// EX operand forwarding selects for both sources.
// MEM beats WB; x0 is never forwarded.
module ex_fwd_unit
  import ex_issue_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] exRs1Addr,
  input  logic [REG_AW-1:0] exRs2Addr,
  input  logic [REG_AW-1:0] memRdAddr,
  input  logic [REG_AW-1:0] wbRdAddr,
  input  logic              memRegWrite,
  input  logic              wbRegWrite,
  output logic [1:0]        fwdASel,
  output logic [1:0]        fwdBSel
);

  function automatic logic [1:0] pick(
    input logic [REG_AW-1:0] src
  );
    logic mem_hit;
    logic wb_hit;
    mem_hit = memRegWrite && (memRdAddr != '0)
           && (memRdAddr == src);
    wb_hit  = wbRegWrite && (wbRdAddr != '0)
           && (wbRdAddr == src);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_RF;
  endfunction

  assign fwdASel = pick(exRs1Addr);
  assign fwdBSel = pick(exRs2Addr);

endmodule

// File: rtl/ex_issue_ctrl.sv
// ID/EX register and issue sequencer: bubbles, flush kill window,
// back-pressure hold and operand forwarding selects.
module ex_issue_ctrl
  import ex_issue_ctrl_pkg::*;
#(
  parameter int OP_W         = 12,
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  ex_issue_ctrl_if.slave    id_bus,
  input  logic              exReady,
  input  logic              branchTaken,
  output logic              flushOut,
  output logic              exValid,
  output logic [OP_W-1:0]   exOp,
  output logic [REG_AW-1:0] exRs1Addr,
  output logic [REG_AW-1:0] exRs2Addr,
  output logic [REG_AW-1:0] exRdAddr,
  output logic              exIsLoad,
  output logic              exRegWrite,
  input  logic [REG_AW-1:0] memRdAddr,
  input  logic [REG_AW-1:0] wbRdAddr,
  input  logic              memRegWrite,
  input  logic              wbRegWrite,
  output logic [1:0]        fwdASel,
  output logic [1:0]        fwdBSel
);

  localparam logic [OP_W-1:0] NOP = OP_W'(EX_NOP);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       flush, load_use, rs1_hit, rs2_hit;
  logic       ld_bub, ld_id, ready;

  assign flush = branchTaken & exValid & exReady;
  assign flushOut = flush;
  assign id_bus.idReady = ready;

  assign rs1_hit = id_bus.idUseRs1
                && (id_bus.idRs1Addr == exRdAddr);
  assign rs2_hit = id_bus.idUseRs2
                && (id_bus.idRs2Addr == exRdAddr);
  assign load_use = exValid && exIsLoad && exRegWrite
                 && (exRdAddr != '0) && id_bus.idValid
                 && (rs1_hit || rs2_hit);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_bub  = 1'b0;
    ld_id   = 1'b0;
    ready   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (flush) begin
          ld_bub = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_KILL;
            cnt_d   = 3'(FLUSH_CYCLES - 1);
          end
        end else if (!exReady) begin
          ld_bub = 1'b0;
        end else if (load_use) begin
          ld_bub = 1'b1;
        end else begin
          ready = 1'b1;
          ld_id = 1'b1;
        end
      end
      ST_KILL: begin
        ld_bub = exReady;
        if (cnt_q == 3'd1) state_d = ST_RUN;
        else               cnt_d = cnt_q - 3'd1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bubbles clear rd and flags so they never forward or stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exValid    <= 1'b0;
      exOp       <= NOP;
      exRs1Addr  <= '0;
      exRs2Addr  <= '0;
      exRdAddr   <= '0;
      exIsLoad   <= 1'b0;
      exRegWrite <= 1'b0;
    end else if (ld_bub) begin
      exValid    <= 1'b0;
      exOp       <= NOP;
      exRs1Addr  <= '0;
      exRs2Addr  <= '0;
      exRdAddr   <= '0;
      exIsLoad   <= 1'b0;
      exRegWrite <= 1'b0;
    end else if (ld_id) begin
      exValid    <= id_bus.idValid;
      exOp       <= id_bus.idValid ? id_bus.idExOp : NOP;
      exRs1Addr  <= id_bus.idRs1Addr;
      exRs2Addr  <= id_bus.idRs2Addr;
      exRdAddr   <= id_bus.idRdAddr;
      exIsLoad   <= id_bus.idValid & id_bus.idIsLoad;
      exRegWrite <= id_bus.idValid & id_bus.idRegWrite;
    end
  end

  ex_fwd_unit #(.REG_AW(REG_AW)) u_fwd (
    .exRs1Addr   (exRs1Addr),
    .exRs2Addr   (exRs2Addr),
    .memRdAddr   (memRdAddr),
    .wbRdAddr    (wbRdAddr),
    .memRegWrite (memRegWrite),
    .wbRegWrite  (wbRegWrite),
    .fwdASel     (fwdASel),
    .fwdBSel     (fwdBSel)
  );

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Bench for ex_issue_ctrl: directed hazard/flush/forward cases
// plus random traffic against a behavioural model.
module tb_ex_issue_ctrl;

  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       exReady, branchTaken, flushOut;
  logic       exValid, exIsLoad, exRegWrite;
  logic [11:0] exOp;
  logic [4:0] exRs1Addr, exRs2Addr, exRdAddr;
  logic [4:0] memRdAddr, wbRdAddr;
  logic       memRegWrite, wbRegWrite;
  logic [1:0] fwdASel, fwdBSel;

  int checks = 0;
  int errors = 0;

  ex_issue_ctrl_if #(.OP_W(12), .REG_AW(5)) id_if ();

  ex_issue_ctrl #(
    .OP_W(12), .REG_AW(5), .FLUSH_CYCLES(FC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_bus      (id_if),
    .exReady     (exReady),
    .branchTaken (branchTaken),
    .flushOut    (flushOut),
    .exValid     (exValid),
    .exOp        (exOp),
    .exRs1Addr   (exRs1Addr),
    .exRs2Addr   (exRs2Addr),
    .exRdAddr    (exRdAddr),
    .exIsLoad    (exIsLoad),
    .exRegWrite  (exRegWrite),
    .memRdAddr   (memRdAddr),
    .wbRdAddr    (wbRdAddr),
    .memRegWrite (memRegWrite),
    .wbRegWrite  (wbRegWrite),
    .fwdASel     (fwdASel),
    .fwdBSel     (fwdBSel)
  );

  always #5 clk = ~clk;

  // Model of the EX register contents and the kill window
  bit         m_valid, m_load, m_rw, m_kill;
  logic [11:0] m_op;
  logic [4:0] m_rs1, m_rs2, m_rd;
  int         m_cnt;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic m_bubble();
    m_valid = 0; m_op = 12'h1E0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_load = 0; m_rw = 0;
  endtask

  task automatic m_reset();
    m_bubble();
    m_kill = 0; m_cnt = 0;
  endtask

  function automatic bit e_flush();
    return branchTaken && m_valid && exReady;
  endfunction

  function automatic bit e_lu();
    bit hit;
    hit = (id_if.idUseRs1 && id_if.idRs1Addr == m_rd)
       || (id_if.idUseRs2 && id_if.idRs2Addr == m_rd);
    return m_valid && m_load && m_rw && m_rd != 0
        && id_if.idValid && hit;
  endfunction

  function automatic logic [1:0] e_fwd(input logic [4:0] a);
    if (memRegWrite && memRdAddr != 0 && memRdAddr == a)
      return 2'b01;
    if (wbRegWrite && wbRdAddr != 0 && wbRdAddr == a)
      return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit e_ready();
    return !m_kill && !e_flush() && exReady && !e_lu();
  endfunction

  task automatic model_update();
    bit fl, lu;
    if (rst) begin
      m_reset();
      return;
    end
    fl = e_flush();
    lu = e_lu();
    if (m_kill) begin
      if (exReady) m_bubble();
      if (m_cnt == 1) m_kill = 0;
      else m_cnt--;
    end else if (fl) begin
      m_bubble();
      if (FC > 1) begin
        m_kill = 1;
        m_cnt = FC - 1;
      end
    end else if (!exReady) begin
      m_kill = 0;
    end else if (lu) begin
      m_bubble();
    end else begin
      m_valid = id_if.idValid;
      m_op = id_if.idValid ? id_if.idExOp : 12'h1E0;
      m_rs1 = id_if.idRs1Addr;
      m_rs2 = id_if.idRs2Addr;
      m_rd = id_if.idRdAddr;
      m_load = id_if.idValid && id_if.idIsLoad;
      m_rw = id_if.idValid && id_if.idRegWrite;
    end
  endtask

  task automatic compare_all();
    chk("exValid", 32'(exValid), 32'(m_valid));
    chk("exOp", 32'(exOp), 32'(m_op));
    chk("exRs1", 32'(exRs1Addr), 32'(m_rs1));
    chk("exRs2", 32'(exRs2Addr), 32'(m_rs2));
    chk("exRd", 32'(exRdAddr), 32'(m_rd));
    chk("exIsLoad", 32'(exIsLoad), 32'(m_load));
    chk("exRegWrite", 32'(exRegWrite), 32'(m_rw));
    chk("idReady", 32'(id_if.idReady), 32'(e_ready()));
    chk("flushOut", 32'(flushOut), 32'(e_flush()));
    chk("fwdA", 32'(fwdASel), 32'(e_fwd(m_rs1)));
    chk("fwdB", 32'(fwdBSel), 32'(e_fwd(m_rs2)));
  endtask

  // Inputs are set at negedge; compare, clock, update model.
  task automatic step();
    #1 compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    id_if.idValid = 0; id_if.idExOp = 0;
    id_if.idRs1Addr = 0; id_if.idRs2Addr = 0;
    id_if.idRdAddr = 0;
    id_if.idUseRs1 = 0; id_if.idUseRs2 = 0;
    id_if.idIsLoad = 0; id_if.idRegWrite = 0;
    exReady = 1; branchTaken = 0;
    memRdAddr = 0; wbRdAddr = 0;
    memRegWrite = 0; wbRegWrite = 0;
  endtask

  task automatic set_id(input logic [11:0] op,
                        input logic [4:0] rs1, rs2, rd,
                        input bit u1, u2, ld, rw);
    id_if.idValid = 1; id_if.idExOp = op;
    id_if.idRs1Addr = rs1; id_if.idRs2Addr = rs2;
    id_if.idRdAddr = rd;
    id_if.idUseRs1 = u1; id_if.idUseRs2 = u2;
    id_if.idIsLoad = ld; id_if.idRegWrite = rw;
  endtask

  initial begin
    rst = 1;
    idle();
    m_reset();
    #1;
    chk("rst_exValid", 32'(exValid), 32'h0);
    chk("rst_exOp", 32'(exOp), 32'h1E0);
    chk("rst_exRegWrite", 32'(exRegWrite), 32'h0);
    @(negedge clk);
    step();
    rst = 0;
    #1 chk("rel_idReady", 32'(id_if.idReady), 32'h1);
    step();

    // reset while EX holds a valid instruction
    set_id(12'h123, 5'd1, 5'd2, 5'd3, 1, 1, 0, 1);
    step();
    rst = 1;
    #1;
    chk("mid_rst_valid", 32'(exValid), 32'h0);
    chk("mid_rst_op", 32'(exOp), 32'h1E0);
    m_reset();
    step();
    rst = 0;
    idle();
    #1 chk("mid_rel_ready", 32'(id_if.idReady), 32'h1);
    step();

    // load-use: lw x5 then add using x5 as rs2
    set_id(12'h0A5, 5'd1, 5'd0, 5'd5, 1, 0, 1, 1);
    step();
    set_id(12'h0C7, 5'd1, 5'd5, 5'd6, 1, 1, 0, 1);
    #1 chk("lu_idReady", 32'(id_if.idReady), 32'h0);
    step();
    chk("lu_bubble", 32'(exValid), 32'h0);
    #1 chk("lu_ready_back", 32'(id_if.idReady), 32'h1);
    step();
    chk("lu_issue_valid", 32'(exValid), 32'h1);
    chk("lu_issue_rd", 32'(exRdAddr), 32'h6);

    // load to x0: no bubble
    set_id(12'h0A5, 5'd1, 5'd0, 5'd0, 1, 0, 1, 1);
    step();
    set_id(12'h0C7, 5'd0, 5'd0, 5'd6, 1, 1, 0, 1);
    #1 chk("lu_x0_ready", 32'(id_if.idReady), 32'h1);
    step();

    // rs2 matches but is not read: no bubble
    set_id(12'h0A5, 5'd1, 5'd0, 5'd5, 1, 0, 1, 1);
    step();
    set_id(12'h0C7, 5'd1, 5'd5, 5'd6, 0, 0, 0, 1);
    #1 chk("lu_nouse_ready", 32'(id_if.idReady), 32'h1);
    step();

    // taken branch with a two-cycle kill window
    set_id(12'h20E, 5'd1, 5'd2, 5'd0, 1, 1, 0, 0);
    step();
    branchTaken = 1;
    set_id(12'h111, 5'd3, 5'd4, 5'd9, 1, 1, 0, 1);
    #1;
    chk("br_flushOut", 32'(flushOut), 32'h1);
    chk("br_idReady0", 32'(id_if.idReady), 32'h0);
    step();
    branchTaken = 0;
    #1;
    chk("br_valid1", 32'(exValid), 32'h0);
    chk("br_idReady1", 32'(id_if.idReady), 32'h0);
    step();
    #1;
    chk("br_valid2", 32'(exValid), 32'h0);
    chk("br_idReady2", 32'(id_if.idReady), 32'h1);
    step();
    chk("br_run_valid", 32'(exValid), 32'h1);

    // back-pressure hold with a branch raised mid-hold
    set_id(12'h3C5, 5'd7, 5'd8, 5'd12, 1, 1, 0, 1);
    step();
    set_id(12'h001, 5'd1, 5'd1, 5'd13, 1, 1, 0, 1);
    exReady = 0;
    for (int i = 0; i < 3; i++) begin
      branchTaken = (i == 1);
      #1;
      chk("bp_op", 32'(exOp), 32'h3C5);
      chk("bp_rd", 32'(exRdAddr), 32'hC);
      chk("bp_idReady", 32'(id_if.idReady), 32'h0);
      chk("bp_flushOut", 32'(flushOut), 32'h0);
      step();
    end
    exReady = 1;
    branchTaken = 0;

    // forwarding priority and x0 suppression
    set_id(12'h055, 5'd7, 5'd0, 5'd1, 1, 1, 0, 1);
    step();
    idle();
    memRdAddr = 7; wbRdAddr = 7;
    memRegWrite = 1; wbRegWrite = 1;
    #1 chk("fwd_mem", 32'(fwdASel), 32'h1);
    memRegWrite = 0;
    #1 chk("fwd_wb", 32'(fwdASel), 32'h2);
    memRegWrite = 1;
    set_id(12'h055, 5'd0, 5'd0, 5'd1, 1, 1, 0, 1);
    step();
    memRdAddr = 0; wbRdAddr = 0;
    #1 chk("fwd_x0", 32'(fwdASel), 32'h0);
    step();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      id_if.idValid = ($urandom_range(0, 3) != 0);
      id_if.idExOp = 12'($urandom);
      id_if.idRs1Addr = 5'($urandom_range(0, 7));
      id_if.idRs2Addr = 5'($urandom_range(0, 7));
      id_if.idRdAddr = 5'($urandom_range(0, 7));
      id_if.idUseRs1 = 1'($urandom);
      id_if.idUseRs2 = 1'($urandom);
      id_if.idIsLoad = ($urandom_range(0, 2) == 0);
      id_if.idRegWrite = 1'($urandom);
      exReady = ($urandom_range(0, 4) != 0);
      branchTaken = ($urandom_range(0, 5) == 0);
      memRdAddr = 5'($urandom_range(0, 7));
      wbRdAddr = 5'($urandom_range(0, 7));
      memRegWrite = 1'($urandom);
      wbRegWrite = 1'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      if (rst) begin
        #1 m_reset();
      end
      step();
      rst = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_issue_ctrl.md
Name: ex_issue_ctrl

Overview:
- ID/EX pipeline-register controller for the RVX core: captures the 12-bit EX op word (`{branchOp[2:0], aluOp[3:0], aluSrcASelect, aluSrcBSelect, aluEn, branchEn, workEn}`) plus register addresses from ID and issues them to EX.
- Sequences the EX datapath: load-use bubble insertion, branch/jump flush with a configurable kill window, downstream back-pressure hold, and EX operand-forwarding selects.
- Sits between the ID decoder and the ALU/branch unit.

Parameters:
- OP_W, 12, width of the EX op word
- REG_AW, 5, register address width
- FLUSH_CYCLES, 1, cycles of wrong-path ID input discarded after a taken branch/jump (1..7)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- idValid  in  1  ID holds a valid instruction
- idExOp  in  OP_W  decoded EX op word
- idRs1Addr, idRs2Addr, idRdAddr  in  REG_AW each  ID register addresses
- idUseRs1, idUseRs2  in  1 each  instruction reads rs1/rs2
- idIsLoad, idRegWrite  in  1 each  load / writes rd
- idReady  out  1  ID may advance (0 = stall ID and IF)
- exReady  in  1  EX/MEM accepts the current EX instruction
- branchTaken  in  1  EX resolved a taken branch or jump for the current EX instruction
- flushOut  out  1  kill IF/ID contents and redirect PC
- exValid  out  1  EX register holds a valid instruction
- exOp  out  OP_W  registered op word
- exRs1Addr, exRs2Addr, exRdAddr  out  REG_AW each  registered addresses
- exIsLoad, exRegWrite  out  1 each  registered flags
- memRdAddr, wbRdAddr  in  REG_AW each  destination register in MEM / WB
- memRegWrite, wbRegWrite  in  1 each  MEM / WB write enables
- fwdASel, fwdBSel  out  2 each  operand source: 00 regfile, 01 MEM, 10 WB

Behaviour:
- Reset (async, takes effect immediately):
  - exValid=0, exOp=EX_NOP (12'h1E0: aluOp=1111, all enables 0).
  - All address registers 0; exIsLoad=0, exRegWrite=0.
  - FSM=RUN, flush counter 0.
- FSM states:
  - RUN: normal issue.
  - KILL: counting wrong-path cycles.
- flush = branchTaken & exValid & exReady; combinational to flushOut. branchTaken is ignored when exValid=0 or exReady=0.
- loadUse = exValid & exIsLoad & exRegWrite & (exRdAddr!=0) & idValid & ((idUseRs1 & idRs1Addr==exRdAddr) | (idUseRs2 & idRs2Addr==exRdAddr)).
- Priority each cycle (RUN state):
  1. flush: EX reg loads bubble (exValid=0, exOp=EX_NOP); idReady=0; if FLUSH_CYCLES>1, go to KILL with counter=FLUSH_CYCLES-1, else stay in RUN.
  2. exReady=0: EX reg holds all fields; idReady=0.
  3. loadUse: EX reg loads bubble; idReady=0 (exactly one-cycle bubble per load-use pair).
  4. otherwise: idReady=1; EX reg loads ID fields with exValid=idValid. When idValid=0, exOp=EX_NOP.
- KILL state:
  - idReady=0; EX reg loads bubble when exReady=1.
  - Counter decrements each cycle; at 1, return to RUN.
  - A new flush in KILL cannot occur, because exValid=0.
- Forwarding, combinational from registered EX addresses:
  - fwdASel=01 if memRegWrite & memRdAddr!=0 & memRdAddr==exRs1Addr.
  - Else 10 if the same WB condition holds.
  - Else 00.
  - fwdBSel uses the same rule with exRs2Addr.
  - MEM has priority over WB; x0 is never forwarded.
- Latency: ID to EX outputs is 1 cycle; flushOut is 0-cycle (combinational).
- Bubbles never forward a rd: exRegWrite=0 whenever exValid=0.

Decomposition:
- Shared package/include (alongside RVX_Info.v):
  - EX_NOP.
  - Op-word field offsets (BR_OP_LSB=9, ALU_OP_LSB=5, SRC_A=4, SRC_B=3, ALU_EN=2, BR_EN=1, WORK_EN=0).
  - FWD_RF/FWD_MEM/FWD_WB codes.
  - State encodings.
- One sub-module: ex_fwd_unit (combinational forwarding compare, instanced once per operand or once with both).

Test Plan:
- Reset mid-stream: assert rst while exValid=1 → exValid=0 and exOp=12'h1E0 within the same cycle; idReady=1 after release with idValid=0.
- Load-use hazard:
  - Setup: EX holds lw x5 (exIsLoad=1, exRdAddr=5); ID holds add with idRs2Addr=5, idUseRs2=1.
  - Next edge: exValid=0, idReady=0 for exactly one cycle.
  - Following edge: the add issues.
- Load-use negatives, each → no bubble:
  - load with rd=x0;
  - rs match with idUseRs2=0.
- Taken branch with FLUSH_CYCLES=2:
  - Stimulus: branchTaken=1 with exValid=1, exReady=1.
  - Response: flushOut=1 that cycle, then exValid=0 for 2 cycles, idReady=0 for 2 cycles, then RUN.
- Back-pressure:
  - exReady=0 for 3 cycles → exOp/exRdAddr are stable and idReady=0.
  - branchTaken raised during the hold → flushOut=0.
- Forwarding:
  - exRs1Addr=7 with memRdAddr=7 and wbRdAddr=7, both write enables high → fwdASel=01.
  - memRegWrite=0 → fwdASel=10.
  - exRs1Addr=0 → fwdASel=00.
